// File: rtl/sa_result_drain_if.sv
// sa_result_drain_if
//   Groups the tile control, core read port and output stream of the result drain.
//   Ports (all signals internal to the interface):
//     start, tile_len, relu_en  - tile control, sampled on an accepted start
//     busy, tile_done           - tile status
//     r_read, routport, rvalidport - pop port towards the systolic core
//     m_valid, m_ready, m_data, m_last - output valid/ready stream
//   Modports: slave = drain block, master = host/core side driving it.
interface sa_result_drain_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned OUT_W  = 8,
  parameter int unsigned CNT_W  = 16
) ();
  logic              start;
  logic [CNT_W-1:0]  tile_len;
  logic              relu_en;
  logic              busy;
  logic              r_read;
  logic [DATA_W-1:0] routport;
  logic              rvalidport;
  logic              m_valid;
  logic              m_ready;
  logic [OUT_W-1:0]  m_data;
  logic              m_last;
  logic              tile_done;

  modport slave (
    input  start, tile_len, relu_en, routport, rvalidport, m_ready,
    output busy, r_read, m_valid, m_data, m_last, tile_done
  );

  modport master (
    output start, tile_len, relu_en, routport, rvalidport, m_ready,
    input  busy, r_read, m_valid, m_data, m_last, tile_done
  );
endinterface

// File: rtl/sa_result_drain.sv
// sa_result_drain
//   Pops result words from the systolic core, applies optional ReLU, arithmetic
//   right-shift and signed saturation, buffers them in a show-ahead FIFO and
//   streams them out with per-tile last/done framing.
//   Ports:
//     clk    - clock, rising edge
//     rstn   - synchronous reset, active high
//     io_bus - sa_result_drain_if.slave: tile control, core pop port, output stream
module sa_result_drain #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned OUT_W  = 8,
  parameter int unsigned SHIFT  = 4,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned CNT_W  = 16
) (
  input logic              clk,
  input logic              rstn,
  sa_result_drain_if.slave io_bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  localparam logic signed [DATA_W-1:0] SatMax = DATA_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [DATA_W-1:0] SatMin = ~SatMax;

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e             r_state, w_state_d;
  logic [CNT_W-1:0]   r_len;
  logic               r_relu;
  logic [CNT_W-1:0]   r_acc_cnt;
  logic [CNT_W-1:0]   r_out_cnt;
  logic               r_done;

  logic               r_stage_valid;
  logic [OUT_W-1:0]   r_stage_data;
  logic               r_stage_last;

  logic [OUT_W-1:0]   r_mem_data [DEPTH];
  logic               r_mem_last [DEPTH];
  logic [AW-1:0]      r_wptr;
  logic [AW-1:0]      r_rptr;
  logic [CW-1:0]      r_count;

  logic               w_accept;
  logic               w_rd;
  logic               w_final;
  logic               w_space;
  logic               w_m_valid;
  logic               w_pop;
  logic [CNT_W-1:0]   w_len_m1;

  logic signed [DATA_W-1:0] w_x;
  logic signed [DATA_W-1:0] w_y;
  logic signed [DATA_W-1:0] w_z;
  logic [OUT_W-1:0]         w_sat;

  assign w_len_m1  = r_len - CNT_W'(1);
  assign w_m_valid = (r_count != '0);
  assign w_pop     = w_m_valid && io_bus.m_ready;
  // The staged word is already committed to a FIFO slot, so count it as occupied.
  assign w_space   = (r_count + CW'(r_stage_valid)) < CW'(DEPTH);

  // FSM next state and core pop strobe
  always_comb begin
    w_state_d = r_state;
    w_accept  = 1'b0;
    w_rd      = 1'b0;
    w_final   = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (io_bus.start && (io_bus.tile_len != '0)) begin
          w_accept  = 1'b1;
          w_state_d = StRun;
        end
      end
      StRun: begin
        w_rd = io_bus.rvalidport && (r_acc_cnt < r_len) && w_space;
        if (w_rd && (r_acc_cnt == w_len_m1)) begin
          w_state_d = StDrain;
        end
      end
      StDrain: begin
        if (w_pop && (r_out_cnt == w_len_m1)) begin
          w_final   = 1'b1;
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Requantization of the word being popped this cycle
  always_comb begin
    w_x = signed'(io_bus.routport);
    w_y = (r_relu && w_x[DATA_W-1]) ? '0 : w_x;
    w_z = w_y >>> SHIFT;
    if (w_z > SatMax) begin
      w_sat = {1'b0, {(OUT_W - 1){1'b1}}};
    end else if (w_z < SatMin) begin
      w_sat = {1'b1, {(OUT_W - 1){1'b0}}};
    end else begin
      w_sat = w_z[OUT_W-1:0];
    end
  end

  // Tile registers, counters, pipeline stage and FIFO bookkeeping
  always_ff @(posedge clk) begin
    if (rstn) begin
      r_len         <= '0;
      r_relu        <= 1'b0;
      r_acc_cnt     <= '0;
      r_out_cnt     <= '0;
      r_done        <= 1'b0;
      r_stage_valid <= 1'b0;
      r_stage_data  <= '0;
      r_stage_last  <= 1'b0;
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_count       <= '0;
    end else begin
      r_done <= w_final;
      if (w_accept) begin
        r_len     <= io_bus.tile_len;
        r_relu    <= io_bus.relu_en;
        r_acc_cnt <= '0;
        r_out_cnt <= '0;
      end else begin
        if (w_rd) begin
          r_acc_cnt <= r_acc_cnt + CNT_W'(1);
        end
        if (w_pop) begin
          r_out_cnt <= r_out_cnt + CNT_W'(1);
        end
      end

      r_stage_valid <= w_rd;
      if (w_rd) begin
        r_stage_data <= w_sat;
        r_stage_last <= (r_acc_cnt == w_len_m1);
      end

      if (r_stage_valid) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      r_count <= r_count + CW'(r_stage_valid) - CW'(w_pop);
    end
  end

  // FIFO storage needs no reset: the count gates every read.
  always_ff @(posedge clk) begin
    if (r_stage_valid) begin
      r_mem_data[r_wptr] <= r_stage_data;
      r_mem_last[r_wptr] <= r_stage_last;
    end
  end

  assign io_bus.busy      = (r_state != StIdle);
  assign io_bus.r_read    = w_rd;
  assign io_bus.m_valid   = w_m_valid;
  assign io_bus.m_data    = w_m_valid ? r_mem_data[r_rptr] : '0;
  assign io_bus.m_last    = w_m_valid ? r_mem_last[r_rptr] : 1'b0;
  assign io_bus.tile_done = r_done;

endmodule
